uarc_receiver: RTL and testbench

UARC_RECEIVER -- requirements
Module: uarc_receiver

---
 rtl/uarc_pkg.sv | 12 +
 rtl/uarc_fifo.sv | 85 ++++++++
 rtl/uarc_receiver.sv | 165 ++++++++++++++++
 tb/tb_uarc_receiver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uarc_pkg.sv
// rtl/uarc_pkg.sv - shared state type and default sizing for the uarc receiver
package uarc_pkg;

    localparam int DEF_WORD_MAG = 5;
    localparam int DEF_FIFO_MAG = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } state_t;

endpackage

// File: rtl/uarc_fifo.sv
// rtl/uarc_fifo.sv - first-word-fall-through receive FIFO with flush
//
// Ports:
//   clk, reset            clock and synchronous active-low reset
//   push, push_data       write one entry (ignored while full)
//   pop                   remove head (ignored while empty)
//   flush                 empty the FIFO; wins over push and pop
//   full, empty, head     status and current head entry
module uarc_fifo #(
    parameter int WIDTH     = 33,
    parameter int DEPTH_MAG = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int DEPTH = 1 << DEPTH_MAG;
    localparam logic [DEPTH_MAG:0] FULL_COUNT = {1'b1, {DEPTH_MAG{1'b0}}};

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [DEPTH_MAG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_MAG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_MAG:0]   count_q, count_d;
    logic                 push_ok;
    logic                 pop_ok;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed through count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uarc_receiver.sv
// rtl/uarc_receiver.sv - request/ack bus receiver with incept/kill control and receive FIFO
//
// Ports:
//   clk, reset                          clock, synchronous active-low reset
//   enable, kill/incept/send/stream     bus select and request lines
//   *_ack                               registered one-cycle acks
//   data, self_permission, self_address bus payload
//   incept_permission, incept_address   values latched on incept
//   out_valid/out_data/out_stream       FIFO head, out_ready pops it
//   running, run_permission, run_address, killed, drop_count  status
//
// Optional feature: define UARC_RECEIVER_PERM_CHECK_EN to drop (ack but not
// store) send/stream words whose self_permission shares no bit with
// run_permission; drops are counted in drop_count.
module uarc_receiver
    import uarc_pkg::*;
#(
    parameter  int WORD_MAG   = DEF_WORD_MAG,
    parameter  int FIFO_MAG   = DEF_FIFO_MAG,
    localparam int WORD_WIDTH = 1 << WORD_MAG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  kill,
    input  logic                  incept,
    input  logic                  send,
    input  logic                  stream,
    output logic                  kill_ack,
    output logic                  incept_ack,
    output logic                  send_ack,
    output logic                  stream_ack,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic [WORD_WIDTH-1:0] self_permission,
    input  logic [WORD_WIDTH-1:0] self_address,
    input  logic [WORD_WIDTH-1:0] incept_permission,
    input  logic [WORD_WIDTH-1:0] incept_address,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_stream,
    input  logic                  out_ready,
    output logic                  running,
    output logic [WORD_WIDTH-1:0] run_permission,
    output logic [WORD_WIDTH-1:0] run_address,
    output logic                  killed,
    output logic [7:0]            drop_count
);

    state_t                state_q, state_d;
    logic                  kill_ack_q, incept_ack_q, send_ack_q, stream_ack_q;
    logic                  killed_q;
    logic [WORD_WIDTH-1:0] run_perm_q, run_perm_d;
    logic [WORD_WIDTH-1:0] run_addr_q, run_addr_d;

    logic                  eligible, can_push, perm_ok;
    logic                  acc_kill, acc_incept, acc_send, acc_stream;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [WORD_WIDTH:0]   fifo_head;

    wire unused_self_address = &{1'b0, self_address};

    // An ack in flight blocks new acceptance, so a sender still holding its
    // line during the ack cycle is not accepted twice.
    assign eligible   = enable & ~(kill_ack_q | incept_ack_q | send_ack_q | stream_ack_q);
    assign can_push   = (state_q == RUNNING) & ~fifo_full;
    assign acc_kill   = eligible & kill;
    assign acc_incept = eligible & ~kill & incept & (state_q == IDLE);
    assign acc_send   = eligible & ~kill & ~acc_incept & send & can_push;
    assign acc_stream = eligible & ~kill & ~acc_incept & ~send & stream & can_push;

`ifdef UARC_RECEIVER_PERM_CHECK_EN
    logic [7:0] drop_count_q, drop_count_d;

    assign perm_ok = |(self_permission & run_perm_q);

    always_comb begin
        drop_count_d = drop_count_q;
        if ((acc_send | acc_stream) & ~perm_ok & (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_count_q <= 8'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    wire unused_self_permission = &{1'b0, self_permission};

    assign perm_ok    = 1'b1;
    assign drop_count = 8'd0;
`endif

    assign fifo_push = (acc_send | acc_stream) & perm_ok;
    assign fifo_pop  = ~fifo_empty & out_ready;

    always_comb begin
        state_d    = state_q;
        run_perm_d = run_perm_q;
        run_addr_d = run_addr_q;
        if (acc_kill) begin
            state_d = IDLE;
        end else if (acc_incept) begin
            state_d    = RUNNING;
            run_perm_d = incept_permission;
            run_addr_d = incept_address;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            kill_ack_q   <= 1'b0;
            incept_ack_q <= 1'b0;
            send_ack_q   <= 1'b0;
            stream_ack_q <= 1'b0;
            killed_q     <= 1'b0;
            run_perm_q   <= '0;
            run_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            kill_ack_q   <= acc_kill;
            incept_ack_q <= acc_incept;
            send_ack_q   <= acc_send;
            stream_ack_q <= acc_stream;
            killed_q     <= acc_kill;
            run_perm_q   <= run_perm_d;
            run_addr_q   <= run_addr_d;
        end
    end

    // Kill drives flush, which overrides any same-cycle push or pop.
    uarc_fifo #(
        .WIDTH     (WORD_WIDTH + 1),
        .DEPTH_MAG (FIFO_MAG)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({data, acc_stream}),
        .pop       (fifo_pop),
        .flush     (acc_kill),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign kill_ack       = kill_ack_q;
    assign incept_ack     = incept_ack_q;
    assign send_ack       = send_ack_q;
    assign stream_ack     = stream_ack_q;
    assign killed         = killed_q;
    assign running        = (state_q == RUNNING);
    assign run_permission = run_perm_q;
    assign run_address    = run_addr_q;
    assign out_valid      = ~fifo_empty;
    assign out_data       = fifo_head[WORD_WIDTH:1];
    assign out_stream     = fifo_head[0];

endmodule

// File: tb/tb_uarc_receiver.sv
// tb/tb_uarc_receiver.sv - self-checking bench for uarc_receiver
module tb_uarc_receiver;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, enable, kill, incept, send, stream, out_ready;
    logic        kill_ack, incept_ack, send_ack, stream_ack;
    logic [31:0] data, self_permission, self_address, incept_permission, incept_address;
    logic        out_valid, out_stream, running, killed;
    logic [31:0] out_data, run_permission, run_address;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    uarc_receiver dut (
        .clk(clk), .reset(reset), .enable(enable),
        .kill(kill), .incept(incept), .send(send), .stream(stream),
        .kill_ack(kill_ack), .incept_ack(incept_ack), .send_ack(send_ack), .stream_ack(stream_ack),
        .data(data), .self_permission(self_permission), .self_address(self_address),
        .incept_permission(incept_permission), .incept_address(incept_address),
        .out_valid(out_valid), .out_data(out_data), .out_stream(out_stream), .out_ready(out_ready),
        .running(running), .run_permission(run_permission), .run_address(run_address),
        .killed(killed), .drop_count(drop_count)
    );

    // Reference model: transaction-level view of the receiver.
    logic [32:0] m_q[$];
    bit          m_run;
    logic [3:0]  m_ack;
    bit          m_killed;
    logic [31:0] m_rperm, m_raddr;
    int          m_drop;

    function automatic void model_tick();
        bit         free;
        bit         pop;
        int         occ;
        logic [3:0] nack;
        if (!reset) begin
            m_q.delete();
            m_run = 0; m_ack = '0; m_killed = 0;
            m_rperm = '0; m_raddr = '0; m_drop = 0;
            return;
        end
        free = enable && (m_ack == 4'b0000);
        occ  = m_q.size();
        pop  = (occ > 0) && out_ready;
        nack = 4'b0000;
        m_killed = 0;
        if (free && kill) begin
            nack = 4'b1000;
            m_killed = 1;
            m_q.delete();
            m_run = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (free && incept && !m_run) begin
                nack = 4'b0100;
                m_run = 1;
                m_rperm = incept_permission;
                m_raddr = incept_address;
            end else if (free && (send || stream) && m_run && occ < DEPTH) begin
                nack = send ? 4'b0010 : 4'b0001;
`ifdef UARC_RECEIVER_PERM_CHECK_EN
                if ((self_permission & m_rperm) == 0) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_q.push_back({data, !send});
                end
`else
                m_q.push_back({data, !send});
`endif
            end
        end
        m_ack = nack;
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        chk("acks", {kill_ack, incept_ack, send_ack, stream_ack}, m_ack);
        chk("killed", killed, m_killed);
        chk("running", running, m_run);
        chk("out_valid", out_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk("head", {out_data, out_stream}, m_q[0]);
        chk("run_perm_addr", {run_permission, run_address}, {m_rperm, m_raddr});
        chk("drop_count", drop_count, m_drop[7:0]);
    endtask

    task automatic idle_inputs();
        enable = 1'b1; kill = 1'b0; incept = 1'b0; send = 1'b0; stream = 1'b0;
        out_ready = 1'b0; data = '0;
    endtask

    typedef struct {
        logic       en, kl, inc, sd, st, rdy;
        logic [31:0] d;
        logic [3:0] ack;
        logic       run, vld, strm;
        logic [31:0] head;
    } vec_t;

    function automatic vec_t mk(logic en, logic kl, logic inc, logic sd, logic st, logic rdy,
                                logic [31:0] d, logic [3:0] ack, logic run, logic vld,
                                logic strm, logic [31:0] head);
        vec_t v;
        v.en = en; v.kl = kl; v.inc = inc; v.sd = sd; v.st = st; v.rdy = rdy; v.d = d;
        v.ack = ack; v.run = run; v.vld = vld; v.strm = strm; v.head = head;
        return v;
    endfunction

    vec_t tab[36];

    initial begin
        for (int i = 0; i < 10; i++) tab[i] = mk(1,0,0,1,0,0,32'hA, 4'b0000,0,0,0,0);
        tab[10] = mk(1,0,1,0,0,0,0,     4'b0100,1,0,0,0);
        tab[11] = mk(1,0,0,0,0,0,0,     4'b0000,1,0,0,0);
        tab[12] = mk(1,0,0,1,0,0,32'hA, 4'b0010,1,1,0,32'hA);
        tab[13] = mk(1,0,0,0,0,0,0,     4'b0000,1,1,0,32'hA);
        tab[14] = mk(1,0,0,1,0,0,32'hB, 4'b0010,1,1,0,32'hA);
        tab[15] = mk(1,0,0,0,0,0,0,     4'b0000,1,1,0,32'hA);
        tab[16] = mk(1,0,0,1,0,0,32'hC, 4'b0010,1,1,0,32'hA);
        tab[17] = mk(1,0,0,0,0,0,0,     4'b0000,1,1,0,32'hA);
        tab[18] = mk(1,0,0,1,0,0,32'hD, 4'b0010,1,1,0,32'hA);
        tab[19] = mk(1,0,0,0,0,0,0,     4'b0000,1,1,0,32'hA);
        tab[20] = mk(1,0,0,1,0,0,32'hE, 4'b0000,1,1,0,32'hA);
        tab[21] = mk(1,0,0,1,0,0,32'hE, 4'b0000,1,1,0,32'hA);
        tab[22] = mk(1,0,0,1,0,1,32'hE, 4'b0000,1,1,0,32'hB);
        tab[23] = mk(1,0,0,1,0,0,32'hE, 4'b0010,1,1,0,32'hB);
        tab[24] = mk(1,0,0,0,0,1,0,     4'b0000,1,1,0,32'hC);
        tab[25] = mk(1,0,0,0,0,1,0,     4'b0000,1,1,0,32'hD);
        tab[26] = mk(1,0,0,0,0,0,0,     4'b0000,1,1,0,32'hD);
        tab[27] = mk(1,1,0,1,0,1,32'h77,4'b1000,0,0,0,0);
        tab[28] = mk(1,0,0,0,0,0,0,     4'b0000,0,0,0,0);
        tab[29] = mk(1,0,1,0,0,0,0,     4'b0100,1,0,0,0);
        tab[30] = mk(1,0,0,0,0,0,0,     4'b0000,1,0,0,0);
        tab[31] = mk(1,0,0,0,1,0,32'h55,4'b0001,1,1,1,32'h55);
        tab[32] = mk(1,0,0,0,0,0,0,     4'b0000,1,1,1,32'h55);
        tab[33] = mk(1,0,0,1,0,0,32'h66,4'b0010,1,1,1,32'h55);
        tab[34] = mk(1,0,0,0,0,1,0,     4'b0000,1,1,0,32'h66);
        tab[35] = mk(1,0,0,0,0,1,0,     4'b0000,1,0,0,0);

        idle_inputs();
        enable = 1'b0;
        self_permission = 32'hFFFF_FFFF; self_address = 32'h0;
        incept_permission = 32'h3; incept_address = 32'h100;
        reset = 1'b0;
        step(); step();
        chk("reset_state", {kill_ack, incept_ack, send_ack, stream_ack, killed, running, out_valid, drop_count}, 64'h0);
        reset = 1'b1;

        for (int i = 0; i < 36; i++) begin
            enable = tab[i].en; kill = tab[i].kl; incept = tab[i].inc;
            send = tab[i].sd; stream = tab[i].st; out_ready = tab[i].rdy; data = tab[i].d;
            step();
            chk($sformatf("vec%0d_ack", i), {kill_ack, incept_ack, send_ack, stream_ack}, tab[i].ack);
            chk($sformatf("vec%0d_killed", i), killed, tab[i].ack[3]);
            chk($sformatf("vec%0d_run", i), running, tab[i].run);
            chk($sformatf("vec%0d_valid", i), out_valid, tab[i].vld);
            if (tab[i].vld) chk($sformatf("vec%0d_head", i), {out_data, out_stream}, {tab[i].head, tab[i].strm});
            if (i == 10) chk("incept_addr", {run_permission, run_address}, {32'h3, 32'h100});
        end

        // Reset arriving while a stream request is pending and a word is queued.
        idle_inputs();
        stream = 1'b1; data = 32'h98; step();
        stream = 1'b0; step();
        stream = 1'b1; data = 32'h99; reset = 1'b0; step();
        chk("rst_mid_outs", {kill_ack, incept_ack, send_ack, stream_ack, killed, running, out_valid, drop_count}, 64'h0);
        chk("rst_mid_run", {run_permission, run_address}, 64'h0);
        reset = 1'b1; stream = 1'b0; step();
        chk("rst_mid_noack", {kill_ack, incept_ack, send_ack, stream_ack}, 4'b0000);

`ifdef UARC_RECEIVER_PERM_CHECK_EN
        idle_inputs();
        incept = 1'b1; incept_permission = 32'h1; step();
        incept = 1'b0; step();
        self_permission = 32'h2;
        for (int i = 0; i < 300; i++) begin
            send = 1'b1; data = i; step();
            if (i == 0) begin
                chk("perm_ack", send_ack, 1'b1);
                chk("perm_nopush", out_valid, 1'b0);
                chk("perm_drop1", drop_count, 8'd1);
            end
            send = 1'b0; step();
        end
        chk("perm_drop_sat", drop_count, 8'd255);
`endif

        for (int i = 0; i < 2000; i++) begin
            reset             = ($urandom_range(99) != 0);
            enable            = ($urandom_range(9) != 0);
            kill              = ($urandom_range(39) == 0);
            incept            = ($urandom_range(9) == 0);
            send              = ($urandom_range(2) == 0);
            stream            = ($urandom_range(3) == 0);
            out_ready         = $urandom_range(1);
            data              = $urandom;
            self_permission   = 32'(1) << $urandom_range(3);
            self_address      = $urandom;
            incept_permission = 32'(1) << $urandom_range(3);
            incept_address    = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
